// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-way arbiter family.
package arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_N = 32;

  // OR-reduction form keeps this a flat mux tree rather than a priority chain.
  function automatic logic [4:0] onehot2idx(input logic [ARB_MAX_N-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx |= 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational masked priority encoder; in round-robin mode the search
// starts at start_i and wraps modulo N, in fixed mode it starts at 0.
import arb_pkg::*;

module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] start_i,
  input  logic          mode_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0]  eff;
  logic [IW-1:0] base;

  assign eff  = req_i & ~mask_i;
  assign base = (mode_i == ARB_FIXED) ? '0 : start_i;

  function automatic int wrap_idx(input int p);
    return (p >= N) ? p - N : p;
  endfunction

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!any_o && eff[i] && (i == wrap_idx(int'(base) + off))) begin
          any_o = 1'b1;
          idx_o = IW'(i);
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign gnt_o[gi] = any_o && (idx_o == IW'(gi));
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-requester arbiter with registered one-hot grant, runtime round-robin /
// fixed-priority mode and a per-grant hold quantum.
import arb_pkg::*;

module rr_arbiter_n #(
  parameter  int N  = 4,
  parameter  int QW = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          mode,
  input  logic [QW-1:0] quantum,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_vld
);

  arb_state_e state_q, state_d;
  logic [QW-1:0] cnt_q, cnt_d, qmax;
  logic [IW-1:0] last_q, last_d, start;
  logic [N-1:0]  gnt_q, gnt_d, mask;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic          gnt_vld_q, gnt_vld_d;
  logic          owner_req, expired, take;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [ARB_MAX_N-1:0] gnt_ext;

  assign qmax      = (quantum == '0) ? QW'(1) : quantum;
  assign start     = (last_q == IW'(N - 1)) ? '0 : last_q + IW'(1);
  assign owner_req = |(req & gnt_q);
  // >= rather than == so a quantum lowered below cnt expires at once.
  assign expired   = (cnt_q >= qmax);
  assign mask      = (state_q == ST_GRANT && owner_req && expired) ? gnt_q : '0;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i   (req),
    .mask_i  (mask),
    .start_i (start),
    .mode_i  (mode),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: take = pick_any;
      ST_GRANT: begin
        if (!owner_req) begin
          take = pick_any;
          if (!pick_any) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else if (!expired) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + QW'(1);
        end else if (pick_any) begin
          take = 1'b1;
        end else begin
          cnt_d  = QW'(1);
          last_d = gnt_id_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
    if (take) begin
      state_d = ST_GRANT;
      gnt_d   = pick_gnt;
      cnt_d   = QW'(1);
      last_d  = pick_idx;
    end
    gnt_ext          = '0;
    gnt_ext[N-1:0]   = gnt_d;
    gnt_id_d         = IW'(onehot2idx(gnt_ext));
    gnt_vld_d        = |gnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= IW'(N - 1);
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Self-checking bench for rr_arbiter_n at N = 4, 5, 3, 1 and 32.
module tb_rr_arbiter_n;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode;
  logic [3:0] quantum;

  logic [3:0]  req_4, gnt_4;   logic [1:0] id_4;  logic vld_4;
  logic [4:0]  req_5, gnt_5;   logic [2:0] id_5;  logic vld_5;
  logic [2:0]  req_3, gnt_3;   logic [1:0] id_3;  logic vld_3;
  logic [0:0]  req_1, gnt_1;   logic [0:0] id_1;  logic vld_1;
  logic [31:0] req_32, gnt_32; logic [4:0] id_32; logic vld_32;

  rr_arbiter_n #(.N(4), .QW(4)) u_arb4 (.clk(clk), .rst_n(rst_n), .req(req_4), .mode(mode),
    .quantum(quantum), .gnt(gnt_4), .gnt_id(id_4), .gnt_vld(vld_4));
  rr_arbiter_n #(.N(5), .QW(4)) u_arb5 (.clk(clk), .rst_n(rst_n), .req(req_5), .mode(mode),
    .quantum(quantum), .gnt(gnt_5), .gnt_id(id_5), .gnt_vld(vld_5));
  rr_arbiter_n #(.N(3), .QW(4)) u_arb3 (.clk(clk), .rst_n(rst_n), .req(req_3), .mode(mode),
    .quantum(quantum), .gnt(gnt_3), .gnt_id(id_3), .gnt_vld(vld_3));
  rr_arbiter_n #(.N(1), .QW(4)) u_arb1 (.clk(clk), .rst_n(rst_n), .req(req_1), .mode(mode),
    .quantum(quantum), .gnt(gnt_1), .gnt_id(id_1), .gnt_vld(vld_1));
  rr_arbiter_n #(.N(32), .QW(4)) u_arb32 (.clk(clk), .rst_n(rst_n), .req(req_32), .mode(mode),
    .quantum(quantum), .gnt(gnt_32), .gnt_id(id_32), .gnt_vld(vld_32));

  always #5 clk = ~clk;

  typedef struct {
    int          inst;
    logic        rst;
    logic [31:0] req;
    logic        mode;
    logic [3:0]  quantum;
    logic [31:0] want_gnt;
  } vec_t;

  typedef struct {
    int          inst;
    logic [31:0] gnt;
    string       name;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb_q[$];
  logic [31:0] req_sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] idx_of(input logic [31:0] oh);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (oh[i]) r = 32'(i);
    return r;
  endfunction

  function automatic void add(input int inst, input logic rst, input logic [31:0] r,
                              input logic m, input logic [3:0] q, input logic [31:0] w);
    vec_t v;
    v.inst = inst; v.rst = rst; v.req = r; v.mode = m; v.quantum = q; v.want_gnt = w;
    vecs.push_back(v);
  endfunction

  task automatic get_out(input int inst, output logic [31:0] g, output logic [31:0] id,
                         output logic v);
    g = '0; id = '0; v = 1'b0;
    case (inst)
      4:  begin g = 32'(gnt_4);  id = 32'(id_4);  v = vld_4;  end
      5:  begin g = 32'(gnt_5);  id = 32'(id_5);  v = vld_5;  end
      3:  begin g = 32'(gnt_3);  id = 32'(id_3);  v = vld_3;  end
      1:  begin g = 32'(gnt_1);  id = 32'(id_1);  v = vld_1;  end
      32: begin g = gnt_32;      id = 32'(id_32); v = vld_32; end
      default: ;
    endcase
  endtask

  task automatic drive_req(input int inst, input logic [31:0] r);
    case (inst)
      4:  req_4  = r[3:0];
      5:  req_5  = r[4:0];
      3:  req_3  = r[2:0];
      1:  req_1  = r[0:0];
      32: req_32 = r;
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_4 = '0; req_5 = '0; req_3 = '0; req_1 = '0; req_32 = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle of stimulus, queue the expected grant, compare one edge later.
  task automatic step(input int inst, input logic [31:0] r, input logic m,
                      input logic [3:0] q, input logic [31:0] want, input string name);
    exp_t e;
    logic [31:0] g, id;
    logic v;
    drive_req(inst, r);
    mode = m;
    quantum = q;
    e.inst = inst; e.gnt = want; e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    get_out(e.inst, g, id, v);
    check({e.name, ".gnt"}, g, e.gnt);
    check({e.name, ".id"}, id, idx_of(e.gnt));
    check({e.name, ".vld"}, 32'(v), 32'(e.gnt != 0));
  endtask

  task automatic sweep(input int inst, input int n, input int cycles);
    logic [31:0] r, rp, g, id;
    logic v;
    int wait_cnt[32];
    int maxw;
    do_reset();
    mode = 1'b0;
    quantum = 4'd0;
    r = '0;
    g = '0;
    foreach (wait_cnt[i]) wait_cnt[i] = 0;
    req_sb.delete();
    for (int c = 0; c < cycles; c++) begin
      // A requester holds until granted, then may drop; idle ones arrive at random.
      for (int i = 0; i < n; i++) begin
        if (r[i]) begin
          if (g[i] && $urandom_range(1, 0) == 0) r[i] = 1'b0;
        end else begin
          r[i] = ($urandom_range(3, 0) == 0);
        end
      end
      drive_req(inst, r);
      req_sb.push_back(r);
      @(negedge clk);
      rp = req_sb.pop_front();
      get_out(inst, g, id, v);
      check($sformatf("sweep%0d.c%0d.onehot", n, c), g & (g - 32'd1), 32'd0);
      check($sformatf("sweep%0d.c%0d.subset", n, c), g & ~rp, 32'd0);
      check($sformatf("sweep%0d.c%0d.id", n, c), id, idx_of(g));
      check($sformatf("sweep%0d.c%0d.vld", n, c), 32'(v), 32'(g != 0));
      check($sformatf("sweep%0d.c%0d.busy", n, c), 32'(v), 32'(rp != 0));
      if (n == 1) check($sformatf("sweep1.c%0d.follow", c), g, rp);
      maxw = 0;
      for (int i = 0; i < n; i++) begin
        if (rp[i] && !g[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
      end
      n_checks++;
      if (maxw > n) begin
        n_fail++;
        $display("FAIL sweep%0d.c%0d.wait: waited %0d cycles, limit %0d", n, c, maxw, n);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g, id;
    logic v;
    int insts[5] = '{4, 5, 3, 1, 32};
    mode = 1'b0;
    quantum = 4'd1;
    req_4 = '0; req_5 = '0; req_3 = '0; req_1 = '0; req_32 = '0;

    // Reset state on every instance.
    repeat (2) @(negedge clk);
    foreach (insts[k]) begin
      get_out(insts[k], g, id, v);
      check($sformatf("reset%0d.gnt", insts[k]), g, 32'd0);
      check($sformatf("reset%0d.id", insts[k]), id, 32'd0);
      check($sformatf("reset%0d.vld", insts[k]), 32'(v), 32'd0);
    end
    rst_n = 1'b1;

    // N=4 RR quantum 1, all requesting: 0,1,2,3,0,1
    add(4, 1, 'hF, 0, 1, 'h1); add(4, 0, 'hF, 0, 1, 'h2); add(4, 0, 'hF, 0, 1, 'h4);
    add(4, 0, 'hF, 0, 1, 'h8); add(4, 0, 'hF, 0, 1, 'h1); add(4, 0, 'hF, 0, 1, 'h2);
    // N=4 RR quantum 3, req 0101: 0,0,0,2,2,2,0 then drop req[0] in its second cycle
    add(4, 1, 'h5, 0, 3, 'h1); add(4, 0, 'h5, 0, 3, 'h1); add(4, 0, 'h5, 0, 3, 'h1);
    add(4, 0, 'h5, 0, 3, 'h4); add(4, 0, 'h5, 0, 3, 'h4); add(4, 0, 'h5, 0, 3, 'h4);
    add(4, 0, 'h5, 0, 3, 'h1); add(4, 0, 'h5, 0, 3, 'h1); add(4, 0, 'h4, 0, 3, 'h4);
    add(4, 0, 'h4, 0, 3, 'h4);
    // N=4 fixed priority quantum 1: owners 0 and 1 alternate, 2 and 3 never win
    add(4, 1, 'hF, 1, 1, 'h1); add(4, 0, 'hF, 1, 1, 'h2); add(4, 0, 'hF, 1, 1, 'h1);
    add(4, 0, 'hF, 1, 1, 'h2); add(4, 0, 'hF, 1, 1, 'h1);
    // quantum 0 behaves as 1
    add(4, 1, 'h3, 0, 0, 'h1); add(4, 0, 'h3, 0, 0, 'h2); add(4, 0, 'h3, 0, 0, 'h1);
    add(4, 0, 'h3, 0, 0, 'h2);
    // quantum lowered below the running count expires on the next decision
    add(4, 1, 'h3, 0, 4, 'h1); add(4, 0, 'h3, 0, 4, 'h1); add(4, 0, 'h3, 0, 4, 'h1);
    add(4, 0, 'h3, 0, 1, 'h2); add(4, 0, 'h3, 0, 1, 'h1);
    // N=5 fixed quantum 2, req 10010: 1,1,4,4,1,1 then lone req 1 re-granted
    add(5, 1, 'h12, 1, 2, 'h02); add(5, 0, 'h12, 1, 2, 'h02); add(5, 0, 'h12, 1, 2, 'h10);
    add(5, 0, 'h12, 1, 2, 'h10); add(5, 0, 'h12, 1, 2, 'h02); add(5, 0, 'h12, 1, 2, 'h02);
    add(5, 0, 'h02, 1, 2, 'h02); add(5, 0, 'h02, 1, 2, 'h02); add(5, 0, 'h02, 1, 2, 'h02);
    add(5, 0, 'h02, 1, 2, 'h02);
    // N=3 RR: idle, single request, back to idle, then wrap past index 2
    add(3, 1, 'h0, 0, 1, 'h0); add(3, 0, 'h4, 0, 1, 'h4); add(3, 0, 'h0, 0, 1, 'h0);
    add(3, 0, 'h0, 0, 1, 'h0); add(3, 0, 'h7, 0, 1, 'h1); add(3, 0, 'h7, 0, 1, 'h2);
    add(3, 0, 'h7, 0, 1, 'h4); add(3, 0, 'h7, 0, 1, 'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].inst, vecs[i].req, vecs[i].mode, vecs[i].quantum, vecs[i].want_gnt,
           $sformatf("vec%0d", i));
    end

    // Asynchronous reset while requester 2 owns the grant.
    do_reset();
    step(4, 'hF, 0, 1, 'h1, "arst_g0");
    step(4, 'hF, 0, 1, 'h2, "arst_g1");
    step(4, 'hF, 0, 1, 'h4, "arst_g2");
    #2 rst_n = 1'b0;
    #1 get_out(4, g, id, v);
    check("arst.gnt", g, 32'd0);
    check("arst.id", id, 32'd0);
    check("arst.vld", 32'(v), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4, 'hF, 0, 1, 'h1, "arst_first");

    sweep(1, 1, 200);
    sweep(32, 32, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
